fft_seq_ctrl: RTL and testbench
===============================

Name: fft_seq_ctrl

Overview:
Sequencer and address generator for the in-place radix-2 DIT FFT built from two ping-pong two-port RAMs, twiddle ROM and butterfly.
Runs a full frame in four phases:
- load: streams N samples into RAM0 at bit-reversed addresses.
- compute: runs N_2 butterfly stages, ping-ponging between RAM0 and RAM1.
- drain: waits out the butterfly pipeline between stages.
- unload: streams results out in natural order with backpressure.
Parametrised in size and butterfly pipeline latency; adds a forward/inverse mode.

Parameters:
N_2, 11, log2 of point count; N = 2**N_2; legal range 3..12.
BFLY_LAT, 2, cycles from read address presented to butterfly result ready for write (RAM read + butterfly registers); legal range 1..8.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin a frame; honoured only in IDLE
inverse  in  1  sampled with start; selects inverse FFT
in_valid  in  1  load-side sample valid
in_ready  out  1  load-side ready
out_valid  out  1  unload-side data valid (data on RAM port A of the selected bank)
out_ready  in  1  unload-side ready
rd_adra, rd_adrb  out  N_2 each  RAM read addresses
wr_adra, wr_adrb  out  N_2 each  RAM write addresses
we0, we1  out  1 each  RAM0 / RAM1 write enables
wsel_load  out  1  1 = RAM0 write data comes from the input stream, 0 = from the butterfly
rdsel  out  1  0 = butterfly/output reads RAM0, 1 = reads RAM1
twiddleadr  out  N_2-1  twiddle ROM address
twid_conj  out  1  conjugate twiddle (inverse mode)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on the final unload transfer

Behaviour:
- Reset: asynchronous; forces IDLE with every output 0 and all counters 0. Reset mid-frame discards the frame and starts no RAM write.
- States: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.
- IDLE -> LOAD on start. start is ignored while busy. inverse is registered into twid_conj at start and held until return to IDLE.
- LOAD:
  - in_ready=1, wsel_load=1, we0 = in_valid & in_ready.
  - wr_adra = bitrev(cnt), cnt = 0..N-1, incremented per transfer.
  - After transfer N: in_ready drops the same cycle, stage s=0, j=0, go to COMPUTE.
- COMPUTE (stage s, butterfly j = 0..N/2-1, one per cycle):
  - rd_adra = rotl_N2({j,0}, s); rd_adrb = rotl_N2({j,1}, s).
  - twiddleadr = j AND mask, where mask has the top s bits of the (N_2-1)-bit field set. Stage 0 therefore always gives twiddleadr 0.
  - rdsel = s[0]. Writes go to the other bank: we1 if s even, we0 if s odd.
  - wr_adra/wr_adrb and the write enable are the read addresses and issue-valid delayed by exactly BFLY_LAT cycles.
  - After j = N/2-1, go to DRAIN.
- DRAIN:
  - Exactly BFLY_LAT cycles; no reads are issued, pending writes complete.
  - Then s+1 -> COMPUTE, or after s = N_2-1 go to UNLOAD.
  - Stage period = N/2 + BFLY_LAT cycles; compute total = N_2*(N/2+BFLY_LAT). This rules out any read-after-write hazard across stages.
- UNLOAD:
  - rdsel = N_2[0] (bank holding the result); natural-order counter oc = 0..N-1.
  - rd_adra = oc + (out_valid & out_ready), so the synchronous RAM read tracks the next address.
  - out_valid rises on the second UNLOAD cycle and stays high until the last transfer. A held out_ready=0 holds the data; there are no bubbles.
  - On transfer N: done=1 for that cycle, go to IDLE the next cycle.
- We0 and we1 are never both high.
- Addresses wrap only through explicit counter terminal detection; there is no modular overflow.

Decomposition:
- fft_pkg: state enum; functions bitrev(x, N_2) and rotl(x, s, N_2); constant for maximum BFLY_LAT.
- Sub-module fft_dly: BFLY_LAT-deep shift register carrying {valid, bank, adra, adrb} from issue to write. Reset clears the valid bits.

Test Plan:
All scenarios use N_2=3, BFLY_LAT=2.
1. Load: start, then 8 samples with in_valid held high -> wr_adra = 0,4,2,6,1,5,3,7 with we0=1 each cycle; in_ready=0 after the 8th transfer; in_valid gaps stall the counter.
2. Stage 1 addressing:
   - rd_adra = 0,4,1,5; rd_adrb = 2,6,3,7; twiddleadr = 0,0,2,2; rdsel=1.
   - we0 with identical addresses exactly 2 cycles later; we1=0 throughout.
3. Frame timing: COMPUTE+DRAIN lasts 18 cycles (3 x 6); UNLOAD starts with rdsel=1; no read of a stage is issued before the previous stage's last write.
4. Unload with out_ready toggled 1,0,0,1,... -> addresses 0..7 each transferred exactly once in order; done pulses coincident with the 8th handshake; busy falls the next cycle.
5. Start asserted during COMPUTE is ignored; inverse=1 at start -> twid_conj=1 from LOAD through UNLOAD and 0 after IDLE.
6. Reset asserted mid-COMPUTE (s=1, j=2) -> all outputs 0 immediately without waiting for a clock edge; pending delayed writes are suppressed; a following start runs a clean frame.

Source files
------------

// File: rtl/fft_seq_ctrl_pkg.sv
// fft_seq_ctrl_pkg: shared types and address helpers for the FFT sequencer.
package fft_seq_ctrl_pkg;
  localparam int MAX_N2 = 12;
  localparam int MAX_BFLY_LAT = 8;
  typedef logic [MAX_N2-1:0] adr_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD} state_t;
  function automatic adr_t bitrev(adr_t x, int n);
    adr_t y = '0;
    for (int i = 0; i < MAX_N2; i++)
      if (i < n) y = y | (((x >> i) & adr_t'(1)) << (n - 1 - i));
    return y;
  endfunction
  function automatic adr_t rotl(adr_t x, int s, int n);
    return ((x << s) | (x >> (n - s))) & ((adr_t'(1) << n) - adr_t'(1));
  endfunction
  // Top s bits of the (n-1)-bit twiddle field.
  function automatic adr_t twmask(int s, int n);
    return ((adr_t'(1) << (n - 1)) - adr_t'(1)) & ~((adr_t'(1) << (n - 1 - s)) - adr_t'(1));
  endfunction
endpackage

// File: rtl/fft_seq_ctrl_if.sv
// fft_seq_ctrl_if: stream handshakes plus RAM/ROM control bundle of the FFT sequencer.
interface fft_seq_ctrl_if #(parameter int N_2 = 11);
  logic start, inverse, in_valid, in_ready, out_valid, out_ready;
  logic we0, we1, wsel_load, rdsel, twid_conj, busy, done;
  logic [N_2-1:0] rd_adra, rd_adrb, wr_adra, wr_adrb;
  logic [N_2-2:0] twiddleadr;
  modport master (
    input start, inverse, in_valid, out_ready,
    output in_ready, out_valid, we0, we1, wsel_load, rdsel, twid_conj, busy, done,
    output rd_adra, rd_adrb, wr_adra, wr_adrb, twiddleadr
  );
  modport slave (
    output start, inverse, in_valid, out_ready,
    input in_ready, out_valid, we0, we1, wsel_load, rdsel, twid_conj, busy, done,
    input rd_adra, rd_adrb, wr_adra, wr_adrb, twiddleadr
  );
endinterface

// File: rtl/fft_seq_ctrl_dly.sv
// fft_seq_ctrl_dly: fixed-depth shift register aligning butterfly writes with their reads.
module fft_seq_ctrl_dly #(parameter int W = 8, parameter int LAT = 2) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);
  logic [W-1:0] r_sr [LAT];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < LAT; i++) r_sr[i] <= '0;
    else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
    end
  assign o_d = r_sr[LAT-1];
endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: load/compute/drain/unload sequencer for an in-place radix-2 DIT FFT.
module fft_seq_ctrl import fft_seq_ctrl_pkg::*; #(
  parameter int N_2 = 11,
  parameter int BFLY_LAT = 2
) (
  input logic clk,
  input logic reset,
  fft_seq_ctrl_if.master bus
);
  localparam int N = 1 << N_2;
  localparam int JW = N_2 - 1;
  localparam int DCW = $clog2(MAX_BFLY_LAT);
  state_t r_state;
  logic [N_2-1:0] r_cnt, r_oc;
  logic [JW-1:0] r_j;
  logic [3:0] r_s;
  logic [DCW-1:0] r_dcnt;
  logic r_conj, r_ov;
  logic w_issue, w_xfer_in, w_xfer_out, w_last_out, w_dv, w_dbank;
  logic [N_2-1:0] w_adra, w_adrb, w_dadra, w_dadrb;
  assign w_issue = r_state == S_COMPUTE;
  assign w_xfer_in = r_state == S_LOAD && bus.in_valid;
  assign w_xfer_out = r_state == S_UNLOAD && r_ov && bus.out_ready;
  assign w_last_out = w_xfer_out && r_oc == N_2'(N - 1);
  assign w_adra = w_issue ? N_2'(rotl(adr_t'({r_j, 1'b0}), int'(r_s), N_2)) : '0;
  assign w_adrb = w_issue ? N_2'(rotl(adr_t'({r_j, 1'b1}), int'(r_s), N_2)) : '0;
  fft_seq_ctrl_dly #(.W(2 + 2 * N_2), .LAT(BFLY_LAT)) u_dly (
    .clk(clk),
    .rst(reset),
    .i_d({w_issue, r_s[0], w_adra, w_adrb}),
    .o_d({w_dv, w_dbank, w_dadra, w_dadrb})
  );
  always_comb begin
    bus.in_ready = r_state == S_LOAD;
    bus.wsel_load = r_state == S_LOAD;
    bus.we0 = w_xfer_in || (w_dv && w_dbank);
    bus.we1 = w_dv && !w_dbank;
    bus.wr_adra = r_state == S_LOAD ? N_2'(bitrev(adr_t'(r_cnt), N_2)) : w_dadra;
    bus.wr_adrb = w_dadrb;
    bus.rd_adra = r_state == S_UNLOAD ? r_oc + N_2'(w_xfer_out) : w_adra;
    bus.rd_adrb = w_adrb;
    bus.rdsel = r_state == S_UNLOAD ? 1'(N_2 % 2) : (w_issue || r_state == S_DRAIN) && r_s[0];
    bus.twiddleadr = w_issue ? JW'(adr_t'(r_j) & twmask(int'(r_s), N_2)) : '0;
    bus.twid_conj = r_conj;
    bus.busy = r_state != S_IDLE;
    bus.out_valid = r_ov;
    bus.done = w_last_out;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_oc <= '0;
      r_j <= '0;
      r_s <= '0;
      r_dcnt <= '0;
      r_conj <= 1'b0;
      r_ov <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_LOAD;
          r_conj <= bus.inverse;
          r_cnt <= '0;
        end
        S_LOAD: if (w_xfer_in) begin
          r_cnt <= r_cnt == N_2'(N - 1) ? '0 : r_cnt + 1'b1;
          if (r_cnt == N_2'(N - 1)) begin
            r_state <= S_COMPUTE;
            r_s <= '0;
            r_j <= '0;
          end
        end
        S_COMPUTE: begin
          r_j <= r_j == JW'(N / 2 - 1) ? '0 : r_j + 1'b1;
          if (r_j == JW'(N / 2 - 1)) begin
            r_state <= S_DRAIN;
            r_dcnt <= '0;
          end
        end
        // Drain lets the last BFLY_LAT writes land before the next stage reads.
        S_DRAIN: begin
          r_dcnt <= r_dcnt + 1'b1;
          if (r_dcnt == DCW'(BFLY_LAT - 1)) begin
            r_dcnt <= '0;
            if (r_s == 4'(N_2 - 1)) begin
              r_state <= S_UNLOAD;
              r_oc <= '0;
              r_ov <= 1'b0;
            end else begin
              r_s <= r_s + 1'b1;
              r_state <= S_COMPUTE;
            end
          end
        end
        S_UNLOAD: begin
          r_ov <= 1'b1;
          if (w_xfer_out) r_oc <= r_oc + 1'b1;
          if (w_last_out) begin
            r_state <= S_IDLE;
            r_ov <= 1'b0;
            r_oc <= '0;
            r_s <= '0;
            r_conj <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: directed checks of load, stage addressing, frame timing, unload and reset.
module tb_fft_seq_ctrl;
  localparam int N_2 = 3;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int ea [3][4] = '{'{0, 2, 4, 6}, '{0, 4, 1, 5}, '{0, 1, 2, 3}};
  int eb [3][4] = '{'{1, 3, 5, 7}, '{2, 6, 3, 7}, '{4, 5, 6, 7}};
  int et [3][4] = '{'{0, 0, 0, 0}, '{0, 0, 2, 2}, '{0, 1, 2, 3}};
  int el [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  fft_seq_ctrl_if #(.N_2(N_2)) bus ();
  fft_seq_ctrl #(.N_2(N_2), .BFLY_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.in_ready, bus.out_valid, bus.we0, bus.we1, bus.wsel_load,
                bus.rdsel, bus.twid_conj, bus.done, bus.rd_adra, bus.rd_adrb,
                bus.wr_adra, bus.wr_adrb, bus.twiddleadr});
  endfunction
  task automatic run_load(input logic inv, input bit gaps);
    int k = 0;
    bus.start = 1'b1;
    bus.inverse = inv;
    #1 chk("idle_busy", bus.busy, 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.inverse = 1'b0;
    for (int t = 0; t < 20 && k < 8; t++) begin
      bit v = !(gaps && (t == 3 || t == 6));
      bus.in_valid = v;
      #1 chk("ld_rdy", bus.in_ready, 1);
      chk("ld_wsel", bus.wsel_load, 1);
      chk("ld_we0", bus.we0, v);
      chk("ld_we1", bus.we1, 0);
      chk("ld_conj", bus.twid_conj, inv);
      if (v) begin
        chk("ld_adr", bus.wr_adra, el[k]);
        k++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic run_compute(input logic inv, input bit noisy, input int abort_at);
    for (int c = 0; c < 18; c++) begin
      int s = c / 6;
      int p = c % 6;
      bit wr = p >= 2;
      bus.start = noisy;
      #1 chk("cp_busy", bus.busy, 1);
      chk("cp_rdy", bus.in_ready, 0);
      chk("cp_conj", bus.twid_conj, inv);
      chk("cp_we0", bus.we0, wr && s % 2 == 1);
      chk("cp_we1", bus.we1, wr && s % 2 == 0);
      if (p < 4) begin
        chk("cp_rdsel", bus.rdsel, s % 2);
        chk("cp_rda", bus.rd_adra, ea[s][p]);
        chk("cp_rdb", bus.rd_adrb, eb[s][p]);
        chk("cp_tw", bus.twiddleadr, et[s][p]);
      end
      if (wr) begin
        chk("cp_wra", bus.wr_adra, ea[s][p-2]);
        chk("cp_wrb", bus.wr_adrb, eb[s][p-2]);
      end
      if (c == abort_at) begin
        #2 reset = 1'b1;
        #1 chk("rst_async", outs(), 0);
        bus.start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask
  task automatic run_unload(input logic inv);
    logic [N_2-1:0] prev = '0;
    int oc = 0;
    bit fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      bit r = (i % 4 == 0) || (i % 4 == 3);
      bus.out_ready = r;
      #1 chk("ul_rdsel", bus.rdsel, 1);
      chk("ul_busy", bus.busy, 1);
      chk("ul_conj", bus.twid_conj, inv);
      chk("ul_ov", bus.out_valid, i > 0);
      if (i > 0) chk("ul_adr", prev, oc);
      chk("ul_done", bus.done, i > 0 && r && oc == 7);
      if (i > 0 && r) begin
        if (oc == 7) fin = 1'b1;
        oc++;
      end
      prev = bus.rd_adra;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("ul_xfers", oc, 8);
    #1 chk("post_busy", bus.busy, 0);
    chk("post_conj", bus.twid_conj, 0);
    @(negedge clk);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.inverse = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #3 chk("rst_outs", outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle_outs", outs(), 0);
    @(negedge clk);
    run_load(1'b1, 1'b1);
    run_compute(1'b1, 1'b1, -1);
    run_unload(1'b1);
    run_load(1'b0, 1'b0);
    run_compute(1'b0, 1'b0, 8);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("post_rst", outs(), 0);
      @(negedge clk);
    end
    run_load(1'b0, 1'b0);
    run_compute(1'b0, 1'b0, -1);
    run_unload(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
